// File: rtl/sys_defs.sv
// ============================================================================
// sys_defs : shared widths, FU indices and the CDB broadcast packet type.
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_defs;

  localparam int NUM_FU = 4;
  localparam int TAG_W  = 5;
  localparam int PRN_W  = 6;
  localparam int XLEN   = 32;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MULT = 2;
  localparam int FU_LDBR = 3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob_tag;
    logic [PRN_W-1:0] dest_prn;
    logic             has_dest;
    logic [XLEN-1:0]  value;
    logic             take_branch;
  } CDB_PACKET;

endpackage

`default_nettype wire

// File: rtl/rr_grant.sv
// ============================================================================
// rr_grant : combinational round-robin picker, first requester at or after ptr.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_grant #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_FU-1:0] o_gnt,
  output logic [PTR_W-1:0]  o_winner,
  output logic              o_any
);

  int w_idx;

  always_comb begin
    o_gnt    = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      // Modulo keeps a non-power-of-two FU count wrapping correctly.
      w_idx = (int'(i_ptr) + k) % NUM_FU;
      if (!o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_winner     = PTR_W'(w_idx);
        o_any        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : round-robin select of one finished FU result per cycle,
//               registered onto the common data bus. Rev 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int NUM_FU = sys_defs::NUM_FU,
  parameter int TAG_W  = sys_defs::TAG_W,
  parameter int PRN_W  = sys_defs::PRN_W,
  parameter int XLEN   = sys_defs::XLEN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU*PRN_W-1:0] fu_dest_prn,
  input  logic [NUM_FU-1:0]       fu_has_dest,
  input  logic [NUM_FU*XLEN-1:0]  fu_value,
  input  logic [NUM_FU-1:0]       fu_take_branch,
  output logic [NUM_FU-1:0]       fu_ack,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [PRN_W-1:0]        cdb_dest_prn,
  output logic                    cdb_has_dest,
  output logic [XLEN-1:0]         cdb_value,
  output logic                    cdb_take_branch
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  r_ptr;
  logic [NUM_FU-1:0] w_req;
  logic [NUM_FU-1:0] w_gnt;
  logic [PTR_W-1:0]  w_winner;
  logic              w_any;

  logic [TAG_W-1:0]  w_sel_tag;
  logic [PRN_W-1:0]  w_sel_prn;
  logic              w_sel_has_dest;
  logic [XLEN-1:0]   w_sel_value;
  logic              w_sel_take_branch;

  // No FU may see an ack while the bus is being flushed or reset.
  assign w_req  = fu_done & {NUM_FU{~reset & ~squash}};
  assign fu_ack = w_gnt;

  rr_grant #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_rr_grant (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_sel_tag         = '0;
    w_sel_prn         = '0;
    w_sel_has_dest    = 1'b0;
    w_sel_value       = '0;
    w_sel_take_branch = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_gnt[i]) begin
        w_sel_tag         = fu_rob_tag[i*TAG_W +: TAG_W];
        w_sel_prn         = fu_dest_prn[i*PRN_W +: PRN_W];
        w_sel_has_dest    = fu_has_dest[i];
        w_sel_value       = fu_value[i*XLEN +: XLEN];
        w_sel_take_branch = fu_take_branch[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr           <= '0;
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_dest_prn    <= '0;
      cdb_has_dest    <= 1'b0;
      cdb_value       <= '0;
      cdb_take_branch <= 1'b0;
    end else if (squash || !w_any) begin
      cdb_valid       <= 1'b0;
      cdb_rob_tag     <= '0;
      cdb_dest_prn    <= '0;
      cdb_has_dest    <= 1'b0;
      cdb_value       <= '0;
      cdb_take_branch <= 1'b0;
    end else begin
      r_ptr           <= (w_winner == PTR_W'(NUM_FU-1)) ? '0 : w_winner + PTR_W'(1);
      cdb_valid       <= 1'b1;
      cdb_rob_tag     <= w_sel_tag;
      cdb_dest_prn    <= w_sel_prn;
      cdb_has_dest    <= w_sel_has_dest;
      cdb_value       <= w_sel_value;
      cdb_take_branch <= w_sel_take_branch;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : randomized + directed stimulus, queue scoreboard vs model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import sys_defs::*;

  localparam int N    = NUM_FU;
  localparam int NCYC = 3000;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [PRN_W-1:0] prn;
    logic             hd;
    logic [XLEN-1:0]  val;
    logic             tb;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset;
  logic                squash;
  logic [N-1:0]        fu_done;
  logic [N*TAG_W-1:0]  fu_rob_tag;
  logic [N*PRN_W-1:0]  fu_dest_prn;
  logic [N-1:0]        fu_has_dest;
  logic [N*XLEN-1:0]   fu_value;
  logic [N-1:0]        fu_take_branch;
  logic [N-1:0]        fu_ack;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_rob_tag;
  logic [PRN_W-1:0]    cdb_dest_prn;
  logic                cdb_has_dest;
  logic [XLEN-1:0]     cdb_value;
  logic                cdb_take_branch;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done(fu_done), .fu_rob_tag(fu_rob_tag), .fu_dest_prn(fu_dest_prn),
    .fu_has_dest(fu_has_dest), .fu_value(fu_value), .fu_take_branch(fu_take_branch),
    .fu_ack(fu_ack), .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
    .cdb_dest_prn(cdb_dest_prn), .cdb_has_dest(cdb_has_dest),
    .cdb_value(cdb_value), .cdb_take_branch(cdb_take_branch)
  );

  always #5 clock = ~clock;

  // Reference model state: what each FU is presenting, and the arbiter's turn.
  bit               m_done  [N];
  bit [TAG_W-1:0]   m_tag   [N];
  bit [PRN_W-1:0]   m_prn   [N];
  bit               m_hd    [N];
  bit [XLEN-1:0]    m_val   [N];
  bit               m_tb    [N];
  bit               m_acked [N];
  int               m_ptr;

  logic [N-1:0] ack_q [$];
  exp_t         cdb_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           drv_done = 1'b0;

  function automatic void set_fu(int i, bit d, int tag, int prn, bit hd, int val, bit tb);
    m_done[i] = d;
    m_tag[i]  = TAG_W'(tag);
    m_prn[i]  = PRN_W'(prn);
    m_hd[i]   = hd;
    m_val[i]  = XLEN'(val);
    m_tb[i]   = tb;
  endfunction

  function automatic void rand_fu(int i, bit d);
    set_fu(i, d, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
           bit'($urandom_range(0, 1)), int'($urandom), bit'($urandom_range(0, 1)));
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < N; i++) set_fu(i, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endfunction

  task automatic drive_ports(bit r, bit s);
    reset  = r;
    squash = s;
    for (int i = 0; i < N; i++) begin
      fu_done[i]                   = m_done[i];
      fu_rob_tag[i*TAG_W +: TAG_W] = m_tag[i];
      fu_dest_prn[i*PRN_W +: PRN_W] = m_prn[i];
      fu_has_dest[i]               = m_hd[i];
      fu_value[i*XLEN +: XLEN]     = m_val[i];
      fu_take_branch[i]            = m_tb[i];
    end
  endtask

  // Driver: chooses stimulus, predicts grant and next broadcast, pushes both.
  initial begin
    exp_t         e;
    logic [N-1:0] ea;
    bit           r, s;
    int           win;
    m_ptr = 0;
    clear_all();
    for (int i = 0; i < N; i++) m_acked[i] = 1'b0;
    drive_ports(1'b1, 1'b0);
    cdb_q.push_back('0);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clock);
      #1;
      r = (c < 2);
      s = 1'b0;
      if (c < 2 || c == 3 || c == 12 || c == 16 || c == 20) begin
        clear_all();
      end else if (c == 2) begin
        clear_all();
        set_fu(FU_ALU0, 1'b1, 3, 9, 1'b1, 5, 1'b0);
      end else if (c >= 4 && c < 12) begin
        for (int i = 0; i < N; i++) set_fu(i, 1'b1, 10 + i, 20 + i, 1'b1, 100 + i, 1'b0);
      end else if (c == 13) begin
        set_fu(FU_ALU1, 1'b1, 1, 2, 1'b1, 3, 1'b0);
      end else if (c == 14 || c == 15) begin
        if (c == 14) set_fu(FU_ALU0, 1'b1, 4, 5, 1'b1, 6, 1'b0);
        if (!m_done[FU_ALU0] || m_acked[FU_ALU0]) set_fu(FU_ALU0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        set_fu(FU_ALU1, 1'b1, 1, 2, 1'b1, 3, 1'b0);
      end else if (c == 17 || c == 18) begin
        clear_all();
        set_fu(FU_MULT, 1'b1, 17, 33, 1'b1, 32'h1234, 1'b0);
        s = (c == 17);
      end else if (c == 19) begin
        clear_all();
        set_fu(FU_LDBR, 1'b1, 7, 11, 1'b0, 32'hBEEF, 1'b1);
      end else begin
        // Random phase: acked or idle FUs may start a new result; unacked ones hold.
        for (int i = 0; i < N; i++)
          if (m_acked[i] || !m_done[i])
            rand_fu(i, (c >= 30 && c < 38) ? 1'b1 : ($urandom_range(0, 99) < 55));
        if (c == 33 || c == 34) r = 1'b1;
        if (c >= 40) begin
          r = ($urandom_range(0, 59) == 0);
          s = ($urandom_range(0, 11) == 0);
        end
      end
      drive_ports(r, s);

      win = -1;
      if (!r && !s)
        for (int k = 0; k < N; k++)
          if (win < 0 && m_done[(m_ptr + k) % N]) win = (m_ptr + k) % N;

      ea = '0;
      e  = '0;
      if (win >= 0) begin
        ea[win] = 1'b1;
        e = '{v: 1'b1, tag: m_tag[win], prn: m_prn[win], hd: m_hd[win],
              val: m_val[win], tb: m_tb[win]};
      end
      if (r) m_ptr = 0;
      else if (win >= 0) m_ptr = (win + 1) % N;
      for (int i = 0; i < N; i++) m_acked[i] = (i == win);
      ack_q.push_back(ea);
      cdb_q.push_back(e);
    end
    @(negedge clock);
    #1;
    drv_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Monitor: every cycle the DUT presents an ack vector and a bus state.
  initial begin
    exp_t         act, ex;
    logic [N-1:0] ea;
    forever begin
      @(negedge clock);
      if (drv_done) break;
      if (cdb_q.size() > 0 && ack_q.size() > 0) begin
        ea  = ack_q.pop_front();
        ex  = cdb_q.pop_front();
        act = {cdb_valid, cdb_rob_tag, cdb_dest_prn, cdb_has_dest, cdb_value, cdb_take_branch};
        n_checks++;
        if (fu_ack !== ea) begin
          n_fail++;
          $display("FAIL fu_ack @%0t: got %b expected %b", $time, fu_ack, ea);
        end
        n_checks++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL cdb @%0t: got v=%b tag=%0d prn=%0d hd=%b val=%h tb=%b expected v=%b tag=%0d prn=%0d hd=%b val=%h tb=%b",
                   $time, act.v, act.tag, act.prn, act.hd, act.val, act.tb,
                   ex.v, ex.tag, ex.prn, ex.hd, ex.val, ex.tb);
        end
      end
    end
  end

endmodule

`default_nettype wire
